// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit:
// load/store opcodes, FSM state codes and access-size codes.
package mem_stage_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef logic [1:0] size_t;

    localparam size_t SZ_B = 2'd0;
    localparam size_t SZ_H = 2'd1;
    localparam size_t SZ_W = 2'd2;

    // Access size and extension mode implied by a load/store opcode.
    function automatic void decodeSize(input logic [5:0] opcode,
                                       output size_t size,
                                       output logic isUnsigned);
        size       = SZ_W;
        isUnsigned = 1'b0;
        case (opcode)
            OP_LB, OP_SB: size = SZ_B;
            OP_LBU: begin
                size       = SZ_B;
                isUnsigned = 1'b1;
            end
            OP_LH, OP_SH: size = SZ_H;
            OP_LHU: begin
                size       = SZ_H;
                isUnsigned = 1'b1;
            end
            default: size = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Selects the byte/halfword lane from a read word and sign- or zero-extends it.
import mem_stage_pkg::*;

module load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  size_t       size,
    input  logic        unsignedFlag,
    output logic [31:0] loadData
);

    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    always_comb begin
        byteVal = 8'h00;
        case (addr)
            2'd0: byteVal = rdata[7:0];
            2'd1: byteVal = rdata[15:8];
            2'd2: byteVal = rdata[23:16];
            2'd3: byteVal = rdata[31:24];
            default: byteVal = 8'h00;
        endcase
        halfVal = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        loadData = rdata;
        case (size)
            SZ_B: loadData = unsignedFlag ? {24'h000000, byteVal}
                                          : {{24{byteVal[7]}}, byteVal};
            SZ_H: loadData = unsignedFlag ? {16'h0000, halfVal}
                                          : {{16{halfVal[15]}}, halfVal};
            default: loadData = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: request/ready bus master with pipeline stall.
// Optional macro MEM_ALIGN_CHECK_EN suppresses and flags misaligned halfword/word accesses.
import mem_stage_pkg::*;

module mem_access_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       insMEM,
    input  logic [31:0]       ALUresultMEM,
    input  logic [31:0]       writedataMEM,
    input  logic              MemReadMEM,
    input  logic              MemWriteMEM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       dmemout,
    output logic              stall,
    output logic              misalign
);

    logic [1:0]  state;
    logic [5:0]  opcode;
    logic [1:0]  lowAddr;
    logic        access;
    logic        misaligned;
    size_t       size;
    logic        isUnsigned;
    logic [3:0]  byteEn;
    logic [31:0] storeData;

    // Transaction attributes held for formatting the read word in WAIT.
    logic [1:0]  laneLat;
    size_t       sizeLat;
    logic        unsLat;
    logic        loadLat;
    logic [31:0] loadData;

    logic        unusedBits;

    assign opcode     = insMEM[31:26];
    assign lowAddr    = ALUresultMEM[1:0];
    assign access     = MemReadMEM | MemWriteMEM;
    assign unusedBits = ^insMEM[25:0];

    always_comb begin
        size       = SZ_W;
        isUnsigned = 1'b0;
        decodeSize(opcode, size, isUnsigned);
    end

    always_comb begin
        byteEn    = 4'hF;
        storeData = writedataMEM;
        case (size)
            SZ_B: begin
                byteEn    = 4'b0001 << lowAddr;
                storeData = {4{writedataMEM[7:0]}};
            end
            SZ_H: begin
                byteEn    = 4'b0011 << {lowAddr[1], 1'b0};
                storeData = {2{writedataMEM[15:0]}};
            end
            default: begin
                byteEn    = 4'hF;
                storeData = writedataMEM;
            end
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic misalignQ;

    always_comb begin
        misaligned = 1'b0;
        if (size == SZ_H)
            misaligned = lowAddr[0];
        else if (size == SZ_W)
            misaligned = (lowAddr != 2'b00);
    end

    assign misalign = misalignQ;
`else
    assign misaligned = 1'b0;
    assign misalign   = 1'b0;
`endif

    assign stall = ((state == S_IDLE) & access & ~misaligned) | (state == S_WAIT);

    load_align u_load_align (
        .rdata        (mem_rdata),
        .addr         (laneLat),
        .size         (sizeLat),
        .unsignedFlag (unsLat),
        .loadData     (loadData)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            dmemout   <= '0;
            laneLat   <= '0;
            sizeLat   <= SZ_W;
            unsLat    <= 1'b0;
            loadLat   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misalignQ <= 1'b0;
`endif
        end else begin
`ifdef MEM_ALIGN_CHECK_EN
            misalignQ <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (access && misaligned) begin
`ifdef MEM_ALIGN_CHECK_EN
                        misalignQ <= 1'b1;
`endif
                        dmemout <= '0;
                    end else if (access) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWriteMEM;
                        mem_addr  <= {ALUresultMEM[ADDR_W-1:2], 2'b00};
                        mem_be    <= byteEn;
                        mem_wdata <= storeData;
                        laneLat   <= lowAddr;
                        sizeLat   <= size;
                        unsLat    <= isUnsigned;
                        // A simultaneous read+write is treated as a write only.
                        loadLat   <= ~MemWriteMEM;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        if (loadLat)
                            dmemout <= loadData;
                        mem_req <= 1'b0;
                        state   <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage data-memory access unit between the EX/MEM register and the MEM/WB register.
- Decodes the load/store opcode of the instruction in MEM and drives a request/ready bus to data memory.
- Stalls the pipeline until the access completes, then presents the aligned, extended load data on dmemout for MEM/WB to capture.

Parameters:
- ADDR_W, 32, width of mem_addr (low ADDR_W bits of ALUresultMEM).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- insMEM  input  32  instruction in MEM; opcode = insMEM[31:26].
- ALUresultMEM  input  32  effective address.
- writedataMEM  input  32  store data (rt value).
- MemReadMEM  input  1  load in MEM.
- MemWriteMEM  input  1  store in MEM.
- mem_req  output  1  bus request, registered.
- mem_we  output  1  1 = write, registered.
- mem_addr  output  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}), registered.
- mem_be  output  4  byte enables, bit i = byte lane i (little-endian), registered.
- mem_wdata  output  32  lane-replicated store data, registered.
- mem_rdata  input  32  read word, valid when mem_ready=1.
- mem_ready  input  1  completes the current request.
- dmemout  output  32  formatted load data, registered; feeds MEM/WB.
- stall  output  1  combinational; freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB when high.
- misalign  output  1  misaligned-access flag (see Optional Feature).

Behaviour:
- Opcodes: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B. access = MemReadMEM | MemWriteMEM.
- If both MemReadMEM and MemWriteMEM are 1, the access is a write; dmemout is unchanged.
- States:
  - IDLE:
    - With access: load the mem_* registers and go to WAIT.
    - Without access: stay in IDLE.
  - WAIT: mem_req=1, outputs held stable.
    - mem_ready=1: capture the formatted load into dmemout (loads only), clear mem_req, go to DONE.
    - mem_ready=0: stay in WAIT indefinitely.
  - DONE: go to IDLE unconditionally. The next instruction has entered MEM and is evaluated in IDLE.
- stall = (IDLE & access) | WAIT. stall is 0 in DONE, so MEM/WB captures dmemout on that edge.
- Latency: minimum 3 cycles per access (2 stall cycles when mem_ready is returned in the first WAIT cycle). Back-to-back accesses cost 3 cycles each.
- Non-memory instructions: no stall, no request; dmemout holds its last value.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'hF.
- Store data: byte replicated x4, half replicated x2, word as-is.
- Load data:
  - Byte lane selected by addr[1:0]; half lane selected by addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- Reset: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, dmemout=0, misalign=0.
- Reset during WAIT abandons the transaction. Memory must tolerate a request dropped without mem_ready.
- mem_ready while in IDLE or DONE is ignored.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined:
  - Misaligned cases: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0.
  - In IDLE a misaligned access issues no request and produces no stall.
  - misalign is registered: it pulses 1 for one cycle on the following edge, and dmemout is cleared to 0 on that edge.
- Undefined:
  - misalign is tied to 0.
  - Offending low address bits are ignored (halfword uses addr[1], word forces lane 0) and the access proceeds normally.

Decomposition:
- Package mem_stage_pkg:
  - opcode localparams (OP_LB … OP_SW);
  - state encoding (S_IDLE=2'd0, S_WAIT=2'd1, S_DONE=2'd2);
  - size encoding (SZ_B, SZ_H, SZ_W).
- Sub-module load_align: combinational; inputs rdata, addr[1:0], size, unsigned_flag; output 32-bit extended value. Instantiated once.

Test Plan:
- lw, addr 0x104, mem_ready one cycle after mem_req, rdata 0xDEADBEEF -> mem_addr=0x104, mem_be=0xF, stall high 2 cycles, dmemout=0xDEADBEEF in DONE.
- lb addr 0x103, rdata 0x80112233 -> mem_be=0x8, dmemout=0xFFFFFF80; lbu same -> 0x00000080.
- sh addr 0x202, data 0x0000ABCD, mem_ready after 4 WAIT cycles -> mem_we=1, mem_be=0xC, mem_wdata=0xABCDABCD, stall high 5 cycles, dmemout unchanged.
- add (no access) between two lw -> stall stays 0 on the add; each lw costs 3 cycles; no mem_req during the add.
- rst asserted during WAIT -> next cycle state IDLE, mem_req=0, dmemout=0; a later mem_ready is ignored.
- MEM_ALIGN_CHECK_EN, lw addr 0x101 -> no mem_req, no stall, misalign=1 for one cycle, dmemout=0; without macro -> mem_addr=0x100, mem_be=0xF, normal completion.
